// File: rtl/id_decode_stage_if.sv
// IF -> ID handshake, pipeline control inputs and the ID/EX register outputs
// consumed by the EX-stage ALU.
interface id_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [31:0]     if_inst;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;
    logic            stall_in;
    logic            ex_jb;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_opcode;
    logic [2:0]      id_func3;
    logic            id_func7;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [31:0]     id_imm;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_illegal;

    modport master (
        input  if_valid, if_inst, if_pc, stall_in, ex_jb,
        output if_ready, id_valid, id_pc, id_opcode, id_func3, id_func7,
               id_rs1, id_rs2, id_rd, id_imm, id_use_rs1, id_use_rs2,
               id_reg_write, id_mem_read, id_mem_write, id_illegal
    );

    modport slave (
        output if_valid, if_inst, if_pc, stall_in, ex_jb,
        input  if_ready, id_valid, id_pc, id_opcode, id_func3, id_func7,
               id_rs1, id_rs2, id_rd, id_imm, id_use_rs1, id_use_rs2,
               id_reg_write, id_mem_read, id_mem_write, id_illegal
    );
endinterface

// File: rtl/id_decode_stage.sv
// RV32I instruction decode stage: decodes if_inst into the ID/EX register,
// handles load-use bubbles, branch/jump flush and global stall.
module id_decode_stage #(
    parameter int XLEN           = 32,
    parameter bit NOP_ON_ILLEGAL = 1'b1
) (
    input logic               clk,
    input logic               rst,
    id_decode_stage_if.master bus
);
    typedef enum logic [4:0] {
        OP_LOAD   = 5'b00000,
        OP_IALU   = 5'b00100,
        OP_AUIPC  = 5'b00101,
        OP_STORE  = 5'b01000,
        OP_R      = 5'b01100,
        OP_LUI    = 5'b01101,
        OP_BRANCH = 5'b11000,
        OP_JALR   = 5'b11001,
        OP_JAL    = 5'b11011
    } opcode_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      opcode;
        logic [2:0]      func3;
        logic            func7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic            use_rs1;
        logic            use_rs2;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            illegal;
    } entry_t;

    entry_t q, nxt;

    logic [31:0] inst;
    logic [4:0]  opc, rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal, func7, use1, use2, wr, mr, mw;
    logic [31:0] imm;
    logic        hazard;

    assign inst = bus.if_inst;
    assign opc  = inst[6:2];
    assign f3   = inst[14:12];
    assign f7   = inst[31:25];
    assign rs1  = inst[19:15];
    assign rs2  = inst[24:20];
    assign rd   = inst[11:7];

    always_comb begin
        legal = 1'b0;
        func7 = 1'b0;
        imm   = '0;
        use1  = 1'b0;
        use2  = 1'b0;
        wr    = 1'b0;
        mr    = 1'b0;
        mw    = 1'b0;
        case (opc)
            OP_R: begin
                legal = (f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                func7 = inst[30];
                use1  = 1'b1;
                use2  = 1'b1;
                wr    = 1'b1;
            end
            OP_IALU: begin
                if (f3 == 3'b001)
                    legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101)
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else
                    legal = 1'b1;
                func7 = (f3 == 3'b001 || f3 == 3'b101) ? inst[30] : 1'b0;
                imm   = {{20{inst[31]}}, inst[31:20]};
                use1  = 1'b1;
                wr    = 1'b1;
            end
            OP_LOAD: begin
                legal = 1'b1;
                imm   = {{20{inst[31]}}, inst[31:20]};
                use1  = 1'b1;
                wr    = 1'b1;
                mr    = 1'b1;
            end
            OP_STORE: begin
                legal = 1'b1;
                imm   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                use1  = 1'b1;
                use2  = 1'b1;
                mw    = 1'b1;
            end
            OP_BRANCH: begin
                legal = (f3 != 3'b010) && (f3 != 3'b011);
                imm   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                use1  = 1'b1;
                use2  = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                legal = 1'b1;
                imm   = {inst[31:12], 12'b0};
                wr    = 1'b1;
            end
            OP_JAL: begin
                legal = 1'b1;
                imm   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                wr    = 1'b1;
            end
            OP_JALR: begin
                legal = 1'b1;
                imm   = {{20{inst[31]}}, inst[31:20]};
                use1  = 1'b1;
                wr    = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        legal = legal && (inst[1:0] == 2'b11);
        // An undecodable word must not read operands or cause side effects in EX.
        use1 = use1 && legal;
        use2 = use2 && legal;
        wr   = wr && legal && (rd != 5'd0);
        mr   = mr && legal;
        mw   = mw && legal;
    end

    assign hazard = bus.if_valid && q.valid && q.mem_read && (q.rd != 5'd0) &&
                    ((use1 && rs1 == q.rd) || (use2 && rs2 == q.rd));

    assign bus.if_ready = !bus.stall_in && (bus.ex_jb || !hazard);

    always_comb begin
        nxt = '0;
        if (bus.ex_jb || hazard || !bus.if_valid) begin
            nxt = '0;
        end else if (!legal && NOP_ON_ILLEGAL) begin
            nxt.illegal = 1'b1;
        end else begin
            nxt.valid     = 1'b1;
            nxt.pc        = bus.if_pc;
            nxt.opcode    = opc;
            nxt.func3     = f3;
            nxt.func7     = func7;
            nxt.rs1       = rs1;
            nxt.rs2       = rs2;
            nxt.rd        = rd;
            nxt.imm       = imm;
            nxt.use_rs1   = use1;
            nxt.use_rs2   = use2;
            nxt.reg_write = wr;
            nxt.mem_read  = mr;
            nxt.mem_write = mw;
            nxt.illegal   = !legal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (!bus.stall_in)
            q <= nxt;
    end

    assign bus.id_valid     = q.valid;
    assign bus.id_pc        = q.pc;
    assign bus.id_opcode    = q.opcode;
    assign bus.id_func3     = q.func3;
    assign bus.id_func7     = q.func7;
    assign bus.id_rs1       = q.rs1;
    assign bus.id_rs2       = q.rs2;
    assign bus.id_rd        = q.rd;
    assign bus.id_imm       = q.imm;
    assign bus.id_use_rs1   = q.use_rs1;
    assign bus.id_use_rs2   = q.use_rs2;
    assign bus.id_reg_write = q.reg_write;
    assign bus.id_mem_read  = q.mem_read;
    assign bus.id_mem_write = q.mem_write;
    assign bus.id_illegal   = q.illegal;
endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Instruction-decode stage of the 5-stage RV32I core: the producer side of the EX-stage ALU interface.
- Decodes the fetched instruction into the fields EX consumes: 5-bit opcode, func3, single func7 bit, immediate, register addresses and control flags.
- Registers them into the ID/EX pipeline register.
- Owns load-use hazard bubbling, branch/jump flush (from EX's jump/branch-taken signal) and global stall hold.

Parameters:
- XLEN, 32, datapath/PC width.
- NOP_ON_ILLEGAL, 1, if 1 an illegal instruction enters EX as a bubble with id_illegal=1; if 0 it passes with valid=1 and id_illegal=1.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- if_valid  input  1  IF holds a valid instruction.
- if_inst  input  32  fetched instruction word.
- if_pc  input  XLEN  PC of if_inst.
- if_ready  output  1  ID accepts if_inst this cycle (combinational).
- stall_in  input  1  global freeze (memory wait); all ID/EX outputs hold.
- ex_jb  input  1  EX resolved a taken branch or jump this cycle; flush.
- id_valid  output  1  ID/EX entry valid.
- id_pc  output  XLEN  PC of entry.
- id_opcode  output  5  inst[6:2].
- id_func3  output  3  inst[14:12].
- id_func7  output  1  qualified inst[30].
- id_rs1, id_rs2, id_rd  output  5 each  register addresses.
- id_imm  output  32  sign-extended immediate.
- id_use_rs1, id_use_rs2  output  1 each  operand actually read.
- id_reg_write, id_mem_read, id_mem_write  output  1 each  control flags.
- id_illegal  output  1  undecodable instruction.

Behaviour:
- Reset (async, immediate): every registered output is 0, including id_valid. if_ready follows its equation.
- Legal opcodes (inst[1:0] must be 2'b11, else illegal):
  - 01100 R
  - 00100 I-ALU
  - 00000 load
  - 01000 store
  - 11000 branch
  - 01101 lui
  - 00101 auipc
  - 11011 jal
  - 11001 jalr
- Every other opcode is illegal.
- Further illegal cases:
  - R-type with inst[31:25] not 0000000, or 0100000 outside func3 000/101.
  - Shift-immediate with a bad inst[31:25].
  - Branch func3 010/011.
- id_func7 = inst[30] for R-type and for I-ALU func3 001/101; 0 for every other opcode.
- Immediate formats:
  - I: load, I-ALU, jalr; sext inst[31:20].
  - S: sext {inst[31:25],inst[11:7]}.
  - B: sext {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: {inst[31:12],12'b0}.
  - J: sext {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - R-type: id_imm = 0.
- Flags:
  - use_rs1 = R, I-ALU, load, store, branch, jalr.
  - use_rs2 = R, store, branch.
  - reg_write = R, I-ALU, load, lui, auipc, jal, jalr, and only when rd != 0.
  - mem_read = load; mem_write = store.
- Hazard (combinational): asserted when all of the following hold:
  - if_valid, id_valid and id_mem_read;
  - id_rd != 0;
  - (use_rs1 && rs1==id_rd) or (use_rs2 && rs2==id_rd), rs fields taken from if_inst.
- if_ready = !stall_in && (ex_jb || !hazard).
- Register update per cycle, in priority order:
  1. stall_in=1: hold all outputs.
  2. ex_jb=1: id_valid<=0, all flags <=0, and if_inst is discarded. IF redirects itself.
  3. hazard=1: insert one bubble (id_valid<=0, flags<=0). if_inst is not consumed and is re-presented next cycle.
  4. if_valid=1: latch the decoded fields with id_valid=1. For an illegal instruction with NOP_ON_ILLEGAL=1, use id_valid=0 and id_illegal=1.
  5. Otherwise: bubble.
- A bubble clears id_valid, reg_write, mem_read, mem_write and id_illegal. The other fields are don't-care; the implementation zeros them.
- Latency: one cycle, instruction to ID/EX. A load-use pair costs exactly one bubble.
- A hazard is never re-triggered by the bubble itself, because id_valid=0 in the following cycle.

Test Plan:
- Reset with rst pulsed mid-cycle -> all outputs 0 immediately, without waiting for clk; if_ready=1 with stall_in=0.
- 0x002081B3 (add x3,x1,x2), then 0x402081B3 (sub), each at pc 0x100 -> opcode 01100, func3 000, func7 0 then 1, rs1=1, rs2=2, rd=3, reg_write=1, imm=0.
- 0xFE20AE23 (sw x2,-4(x1)) -> imm 0xFFFFFFFC, mem_write=1, reg_write=0. 0x123453B7 (lui x7) -> imm 0x12345000, rd=7. 0x4030D213 (srai) -> func3 101, func7 1.
- 0x0000A283 (lw x5) followed by 0x00528333 (add x6,x5,x5):
  - cycle after lw: if_ready=0 and a bubble enters ID/EX;
  - next cycle: the add enters with valid=1;
  - the same sequence with rd=x0 produces no bubble.
- ex_jb=1 while if_valid=1 -> id_valid=0 next cycle; ex_jb together with hazard -> if_ready=1 and flush wins. stall_in=1 together with ex_jb -> outputs hold and if_ready=0.
- if_inst=0x00000000 or 0xFFFFFFFF -> id_illegal=1, id_valid=0 (default parameter); with NOP_ON_ILLEGAL=0 -> id_valid=1, id_illegal=1.
